router_switch_alloc_4port: RTL and testbench
============================================

ROUTER_SWITCH_ALLOC_4PORT -- requirements
Module: router_switch_alloc_4port

Interface
REQ-001 The block SHALL have parameter DW, default 16, flit data width in bits.
REQ-002 The block SHALL have parameter RR_INIT, default 0, reset value of every output's round-robin pointer (0..3).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  4  per-input head-of-queue flit valid; index 0 LOCAL, 1 X1, 2 X2, 3 Y1.
REQ-006 in_port  input  12  per-input route code, 3 bits each, input i at [3i+2:3i]; codes are the global.v defines.
REQ-007 in_tail  input  4  per-input: the current flit is the last of its packet.
REQ-008 in_data  input  4*DW  per-input flit data, input i at [DW*i+DW-1:DW*i].
REQ-009 out_ready  input  4  per-output downstream can accept a flit; index 0 LOCAL, 1 X1, 2 X2, 3 Y1.
REQ-010 in_pop  output  4  per-input: flit consumed this cycle.
REQ-011 out_valid  output  4  per-output flit transferred this cycle.
REQ-012 out_tail  output  4  per-output tail flag of the transferred flit.
REQ-013 out_data  output  4*DW  per-output crossbar data, same packing as in_data.

Function
REQ-014 Output o SHALL map from route codes: OUT_LOCAL_PORT->0, OUT_X1_PORT->1, OUT_X2_PORT->2, OUT_Y1_PORT->3; EMPTY or any other code SHALL request no output.
REQ-015 Input i SHALL request output o in a cycle iff in_valid[i]=1 and in_port of i maps to o.
REQ-016 Each output SHALL hold state IDLE or LOCKED, a 2-bit owner, and a 2-bit rr_ptr.
REQ-017 In IDLE with at least one requester, the winner SHALL be the first requester in search order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-018 At the edge ending that IDLE cycle, the output SHALL load owner<=winner, rr_ptr<=winner+1 mod 4 and state<=LOCKED; with no requester, the state SHALL be unchanged.
REQ-019 No flit SHALL transfer in an IDLE cycle; first transfer is possible in the cycle after the request (1-cycle allocation latency).
REQ-020 In LOCKED, out_valid[o] and in_pop[owner] SHALL both be in_valid[owner] & out_ready[o], combinationally.
REQ-021 In LOCKED, out_data[o] and out_tail[o] SHALL be in_data and in_tail of the owner.
REQ-022 When a transfer in LOCKED has in_tail=1, the output SHALL return to IDLE at that edge; re-arbitration occurs the following cycle (1-cycle bubble).
REQ-023 A single-flit packet (head with in_tail=1) SHALL lock for exactly one transfer.
REQ-024 In LOCKED, in_valid[owner]=0 or out_ready[o]=0 SHALL hold the lock with no transfer; in_port is not sampled while LOCKED.
REQ-025 Upstream holds in_port stable from request until its tail pops; an input never locks two outputs at once.
REQ-026 Outputs not transferring SHALL drive out_valid=0, out_tail=0, out_data=0; in_pop SHALL be 0 for inputs not transferring.
REQ-027 The four outputs SHALL allocate independently and in parallel in the same cycle.

Reset
REQ-028 On rst_n=0, every output SHALL go to IDLE with owner=0 and rr_ptr=RR_INIT, regardless of any packet in flight.
REQ-029 During reset and in the first cycle after it, out_valid, out_tail, in_pop and out_data SHALL be 0.
REQ-030 A packet interrupted by reset SHALL NOT resume a lock; its remaining flits re-arbitrate as a new request.

Verification
REQ-031 Inputs X1 and Y1 both request OUT_LOCAL_PORT, rr_ptr=0, out_ready=all 1 -> X1 is granted; a 3-flit packet pops on cycles 2-4, Y1 is granted on cycle 5 and transfers from cycle 6.
REQ-032 LOCAL requests X2 and X1 requests Y1 in the same cycle -> both lock; both transfer in parallel from the next cycle.
REQ-033 Locked X2 output with out_ready=0 for 3 cycles mid-packet -> no in_pop, out_valid=0, lock held; transfer resumes when out_ready=1.
REQ-034 Single-flit packet with in_tail=1 -> exactly one out_valid pulse; output is IDLE the next cycle and rr_ptr=owner+1.
REQ-035 rst_n asserted mid-packet -> all outputs are 0 immediately; after release the same input re-requests and wins from rr_ptr=RR_INIT.
REQ-036 in_port=EMPTY with in_valid=1 -> no grant, no pop, all out_valid=0.

Source files
------------

// File: rtl/router_switch_alloc_4port.sv
// 4x4 wormhole switch allocator: per-output round-robin arbitration that locks an
// output to one input until that packet's tail flit transfers, plus the data crossbar.
module router_switch_alloc_4port #(
  parameter int unsigned DW      = 16,
  parameter int unsigned RR_INIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    in_valid,
  input  logic [11:0]   in_port,
  input  logic [3:0]    in_tail,
  input  logic [4*DW-1:0] in_data,
  input  logic [3:0]    out_ready,
  output logic [3:0]    in_pop,
  output logic [3:0]    out_valid,
  output logic [3:0]    out_tail,
  output logic [4*DW-1:0] out_data
);

  // Route codes mirror the global route defines.
  localparam logic [2:0] OUT_EMPTY      = 3'd0;
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd1;
  localparam logic [2:0] OUT_X1_PORT    = 3'd2;
  localparam logic [2:0] OUT_X2_PORT    = 3'd3;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd4;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e     state_q [4];
  state_e     state_d [4];
  logic [1:0] owner_q [4];
  logic [1:0] owner_d [4];
  logic [1:0] rr_q    [4];
  logic [1:0] rr_d    [4];

  logic [3:0] req [4];  // req[o][i]: input i requests output o
  logic [3:0] xfer;

  always_comb begin
    for (int o = 0; o < 4; o++) req[o] = '0;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i]) begin
        case (in_port[3*i +: 3])
          OUT_LOCAL_PORT: req[0][i] = 1'b1;
          OUT_X1_PORT:    req[1][i] = 1'b1;
          OUT_X2_PORT:    req[2][i] = 1'b1;
          OUT_Y1_PORT:    req[3][i] = 1'b1;
          OUT_EMPTY:      ;
          default:        ;
        endcase
      end
    end
  end

  // Crossbar: only a locked output with a ready transfer drives anything.
  always_comb begin
    xfer      = '0;
    in_pop    = '0;
    out_valid = '0;
    out_tail  = '0;
    out_data  = '0;
    for (int o = 0; o < 4; o++) begin
      if (state_q[o] == StLocked) begin
        xfer[o] = in_valid[owner_q[o]] & out_ready[o];
        if (xfer[o]) begin
          out_valid[o]          = 1'b1;
          out_tail[o]           = in_tail[owner_q[o]];
          out_data[DW*o +: DW]  = in_data[DW*int'(owner_q[o]) +: DW];
          in_pop[owner_q[o]]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    idx   = '0;
    win   = '0;
    for (int o = 0; o < 4; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      found      = 1'b0;
      idx        = '0;
      win        = '0;
      if (state_q[o] == StIdle) begin
        for (int k = 0; k < 4; k++) begin
          idx = rr_q[o] + 2'(k);
          if (!found && req[o][idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          state_d[o] = StLocked;
          owner_d[o] = win;
          rr_d[o]    = win + 2'd1;
        end
      end else if (xfer[o] && in_tail[owner_q[o]]) begin
        state_d[o] = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 4; o++) begin
        state_q[o] <= StIdle;
        owner_q[o] <= '0;
        rr_q[o]    <= 2'(RR_INIT);
      end
    end else begin
      for (int o = 0; o < 4; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_router_switch_alloc_4port.sv
// Directed testbench for router_switch_alloc_4port: arbitration order, locking,
// backpressure, single-flit packets, reset behaviour and empty routes.
module tb_router_switch_alloc_4port;

  localparam int DW = 16;
  localparam logic [2:0] P_EMPTY = 3'd0;
  localparam logic [2:0] P_LOCAL = 3'd1;
  localparam logic [2:0] P_X1    = 3'd2;
  localparam logic [2:0] P_X2    = 3'd3;
  localparam logic [2:0] P_Y1    = 3'd4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      in_valid;
  logic [11:0]     in_port;
  logic [3:0]      in_tail;
  logic [4*DW-1:0] in_data;
  logic [3:0]      out_ready;
  logic [3:0]      in_pop;
  logic [3:0]      out_valid;
  logic [3:0]      out_tail;
  logic [4*DW-1:0] out_data;

  int tests_run = 0;
  int fails     = 0;

  router_switch_alloc_4port #(.DW(DW), .RR_INIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_port   (in_port),
    .in_tail   (in_tail),
    .in_data   (in_data),
    .out_ready (out_ready),
    .in_pop    (in_pop),
    .out_valid (out_valid),
    .out_tail  (out_tail),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid  = '0;
    in_port   = '0;
    in_tail   = '0;
    in_data   = '0;
    out_ready = 4'hF;
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] p, input logic t,
                       input logic [DW-1:0] d);
    in_valid[i]        = v;
    in_port[3*i +: 3]  = p;
    in_tail[i]         = t;
    in_data[DW*i +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    drive(0, 1'b1, P_Y1, 1'b0, 16'h0A01);
    step();
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL rst_hold_valid_pop got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    tests_run++;
    if (out_data !== '0 || out_tail !== 4'b0) begin
      fails++;
      $display("FAIL rst_hold_data_tail got=%h/%b exp=0/0000", out_data, out_tail);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL rst_first_cycle got=%b/%b/%h exp=0000/0000/0", out_valid, in_pop, out_data);
    end
    step();
    drive(0, 1'b1, P_Y1, 1'b1, 16'h0A02);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b1000 || in_pop !== 4'b0001 || out_data[DW*3 +: DW] !== 16'h0A02) begin
      fails++;
      $display("FAIL rst_first_xfer got=%b/%b/%h exp=1000/0001/0a02", out_valid, in_pop,
               out_data[DW*3 +: DW]);
    end
    step();
    clear_in();
  endtask

  task automatic test_arb_rr();
    drive(1, 1'b1, P_LOCAL, 1'b0, 16'hA101);
    drive(3, 1'b1, P_LOCAL, 1'b1, 16'hB301);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL arb_c1_idle got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010 || out_valid !== 4'b0001 || out_data[DW-1:0] !== 16'hA101) begin
      fails++;
      $display("FAIL arb_c2_x1 got=%b/%b/%h exp=0010/0001/a101", in_pop, out_valid,
               out_data[DW-1:0]);
    end
    step();
    drive(1, 1'b1, P_LOCAL, 1'b0, 16'hA102);
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010 || out_data[DW-1:0] !== 16'hA102 || out_tail !== 4'b0) begin
      fails++;
      $display("FAIL arb_c3_body got=%b/%h/%b exp=0010/a102/0000", in_pop, out_data[DW-1:0],
               out_tail);
    end
    step();
    drive(1, 1'b1, P_LOCAL, 1'b1, 16'hA103);
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010 || out_tail !== 4'b0001 || out_data[DW-1:0] !== 16'hA103) begin
      fails++;
      $display("FAIL arb_c4_tail got=%b/%b/%h exp=0010/0001/a103", in_pop, out_tail,
               out_data[DW-1:0]);
    end
    step();
    drive(1, 1'b0, P_EMPTY, 1'b0, 16'h0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL arb_c5_bubble got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b1000 || out_data[DW-1:0] !== 16'hB301 || out_tail !== 4'b0001) begin
      fails++;
      $display("FAIL arb_c6_y1 got=%b/%h/%b exp=1000/b301/0001", in_pop, out_data[DW-1:0],
               out_tail);
    end
    step();
    clear_in();
  endtask

  task automatic test_parallel();
    drive(0, 1'b1, P_X2, 1'b1, 16'hC001);
    drive(1, 1'b1, P_Y1, 1'b1, 16'hC102);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0) begin
      fails++;
      $display("FAIL par_c1_idle got=%b exp=0000", out_valid);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b1100 || in_pop !== 4'b0011) begin
      fails++;
      $display("FAIL par_c2_valid_pop got=%b/%b exp=1100/0011", out_valid, in_pop);
    end
    tests_run++;
    if (out_data !== {16'hC102, 16'hC001, 16'h0000, 16'h0000}) begin
      fails++;
      $display("FAIL par_c2_data got=%h exp=c102c00100000000", out_data);
    end
    step();
    clear_in();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL par_c3_released got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
  endtask

  task automatic test_backpressure();
    drive(2, 1'b1, P_X2, 1'b0, 16'hD201);
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0100 || in_pop !== 4'b0100 || out_data[DW*2 +: DW] !== 16'hD201) begin
      fails++;
      $display("FAIL bp_first got=%b/%b/%h exp=0100/0100/d201", out_valid, in_pop,
               out_data[DW*2 +: DW]);
    end
    step();
    drive(2, 1'b1, P_X2, 1'b1, 16'hD202);
    for (int k = 0; k < 3; k++) begin
      out_ready = 4'b1011;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0 || in_pop !== 4'b0 || out_data !== '0) begin
        fails++;
        $display("FAIL bp_stall%0d got=%b/%b/%h exp=0000/0000/0", k, out_valid, in_pop, out_data);
      end
      step();
    end
    out_ready = 4'hF;
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0100 || out_tail !== 4'b0100 || out_data[DW*2 +: DW] !== 16'hD202) begin
      fails++;
      $display("FAIL bp_resume got=%b/%b/%h exp=0100/0100/d202", in_pop, out_tail,
               out_data[DW*2 +: DW]);
    end
    step();
    drive(2, 1'b1, P_X2, 1'b1, 16'hD211);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL bp_tail_bubble got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0100 || out_data[DW*2 +: DW] !== 16'hD211) begin
      fails++;
      $display("FAIL bp_relock got=%b/%h exp=0100/d211", out_valid, out_data[DW*2 +: DW]);
    end
    step();
    clear_in();
  endtask

  task automatic test_single_flit();
    drive(2, 1'b1, P_X1, 1'b1, 16'hE201);
    step();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0010 || in_pop !== 4'b0100 || out_tail !== 4'b0010) begin
      fails++;
      $display("FAIL sf_pulse got=%b/%b/%b exp=0010/0100/0010", out_valid, in_pop, out_tail);
    end
    step();
    drive(2, 1'b1, P_X1, 1'b1, 16'hE202);
    drive(3, 1'b1, P_X1, 1'b1, 16'hE301);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL sf_idle_after got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b1000 || out_data[DW*1 +: DW] !== 16'hE301) begin
      fails++;
      $display("FAIL sf_rr_next got=%b/%h exp=1000/e301", in_pop, out_data[DW*1 +: DW]);
    end
    step();
    clear_in();
  endtask

  task automatic test_reset_mid();
    drive(1, 1'b1, P_LOCAL, 1'b0, 16'hF101);
    drive(3, 1'b1, P_LOCAL, 1'b0, 16'hF301);
    step();
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010) begin
      fails++;
      $display("FAIL rm_pre_pop got=%b exp=0010", in_pop);
    end
    step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0 || out_data !== '0 || out_tail !== 4'b0) begin
      fails++;
      $display("FAIL rm_async got=%b/%b/%h/%b exp=0000/0000/0/0000", out_valid, in_pop,
               out_data, out_tail);
    end
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0 || in_pop !== 4'b0) begin
      fails++;
      $display("FAIL rm_release_idle got=%b/%b exp=0000/0000", out_valid, in_pop);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010 || out_data[DW-1:0] !== 16'hF101) begin
      fails++;
      $display("FAIL rm_rewin got=%b/%h exp=0010/f101", in_pop, out_data[DW-1:0]);
    end
    step();
    drive(1, 1'b1, P_LOCAL, 1'b1, 16'hF102);
    @(negedge clk);
    tests_run++;
    if (in_pop !== 4'b0010 || out_tail !== 4'b0001) begin
      fails++;
      $display("FAIL rm_tail got=%b/%b exp=0010/0001", in_pop, out_tail);
    end
    step();
    clear_in();
    step();
  endtask

  task automatic test_empty();
    in_valid  = 4'hF;
    in_port   = {P_EMPTY, 3'd5, 3'd7, P_EMPTY};
    in_tail   = 4'hF;
    in_data   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    out_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0 || in_pop !== 4'b0 || out_data !== '0) begin
        fails++;
        $display("FAIL empty_c%0d got=%b/%b/%h exp=0000/0000/0", k, out_valid, in_pop, out_data);
      end
      step();
    end
    clear_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_arb_rr();
    test_parallel();
    test_backpressure();
    test_single_flit();
    test_reset_mid();
    test_empty();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
